sd_cmd_serial_host: RTL



---
 rtl/sd_cmd_serial_host.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_serial_host.sv
// SD CMD-line serial engine: sends a 48-bit command frame with CRC7, then
// captures and checks the card's 48-bit response and hands it back to the
// command master over a req/ack handshake.
module sd_cmd_serial_host #(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic        CLK_PAD_IO,
    input  logic        RST_PAD_I,
    input  logic [15:0] SETTING_IN,
    input  logic [39:0] CMD_IN,
    input  logic        REQ_IN,
    output logic        ACK_OUT,
    output logic [39:0] CMD_OUT,
    output logic        REQ_OUT,
    input  logic        ACK_IN,
    output logic [7:0]  STATUS,
    input  logic        cmd_dat_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o
);

    // Counter must cover the 49-step TX sequence and the response wait window.
    localparam int unsigned CntMax = (NCR_MAX > 48) ? NCR_MAX : 48;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntFrameBits = CntW'(40);
    localparam logic [CntW-1:0] CntCrcEnd    = CntW'(47);
    localparam logic [CntW-1:0] CntTxDone    = CntW'(48);
    localparam logic [CntW-1:0] CntRxPayload = CntW'(39);
    localparam logic [CntW-1:0] CntRxCrcEnd  = CntW'(46);
    localparam logic [CntW-1:0] CntRxDone    = CntW'(47);
    localparam logic [CntW-1:0] CntTimeout   = CntW'(NCR_MAX);

    localparam logic [1:0] RspNone   = 2'b00;
    localparam logic [1:0] RspNoCrc  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StWaitRsp,
        StRx,
        StDeliver
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [37:0]     cmd_q, cmd_d;
    logic [1:0]      rtype_q, rtype_d;
    logic [6:0]      crc_q, crc_d;
    logic [6:0]      rx_crc_q, rx_crc_d;
    logic            end_q, end_d;
    logic [39:0]     rsp_q, rsp_d;
    logic            req_q, req_d;
    logic            ack_q, ack_d;
    logic [3:0]      status_q, status_d;
    logic            pad_out_q, pad_out_d;
    logic            pad_oe_q, pad_oe_d;

    logic [39:0]     frame40;
    logic [5:0]      tx_idx;
    logic            tx_bit;

    // Bits the block deliberately ignores.
    logic unused_in;
    assign unused_in = ^{SETTING_IN[15:2], CMD_IN[39:38]};

    // One serial step of CRC7 with polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Start and direction bits are always forced to 0,1 on transmit.
    assign frame40 = {2'b01, cmd_q};
    assign tx_idx  = 6'd39 - cnt_q[5:0];

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rtype_d   = rtype_q;
        crc_d     = crc_q;
        rx_crc_d  = rx_crc_q;
        end_d     = end_q;
        rsp_d     = rsp_q;
        req_d     = req_q;
        ack_d     = 1'b0;
        status_d  = status_q;
        pad_out_d = pad_out_q;
        pad_oe_d  = pad_oe_q;
        tx_bit    = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (REQ_IN) begin
                    cmd_d    = CMD_IN[37:0];
                    rtype_d  = SETTING_IN[1:0];
                    status_d = 4'b0001;
                    rsp_d    = '0;
                    crc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StTx;
                end
            end

            StTx: begin
                if (cnt_q == '0) begin
                    ack_d = 1'b1;
                end
                // Header and argument go out while the CRC accumulates; the CRC
                // register is then frozen and shifted out MSB first.
                if (cnt_q < CntFrameBits) begin
                    tx_bit = frame40[tx_idx];
                    crc_d  = crc7_step(crc_q, tx_bit);
                end else if (cnt_q < CntCrcEnd) begin
                    tx_bit = crc_q[3'd6 - cnt_q[2:0]];
                end else begin
                    tx_bit = 1'b1;
                end

                if (cnt_q == CntTxDone) begin
                    pad_oe_d  = 1'b0;
                    pad_out_d = 1'b1;
                    cnt_d     = '0;
                    if (rtype_q == RspNone) begin
                        req_d   = 1'b1;
                        state_d = StDeliver;
                    end else begin
                        state_d = StWaitRsp;
                    end
                end else begin
                    pad_oe_d  = 1'b1;
                    pad_out_d = tx_bit;
                    cnt_d     = cnt_q + CntW'(1);
                end
            end

            StWaitRsp: begin
                // Timeout is acted on one edge after the last allowed sample.
                if (cnt_q == CntTimeout) begin
                    status_d[3] = 1'b1;
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDeliver;
                end else if (!cmd_dat_i) begin
                    // Start bit is zero, so it leaves a zero CRC unchanged.
                    crc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRx;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StRx: begin
                if (cnt_q < CntRxPayload) begin
                    rsp_d = {rsp_q[38:0], cmd_dat_i};
                    crc_d = crc7_step(crc_q, cmd_dat_i);
                end else if (cnt_q < CntRxCrcEnd) begin
                    rx_crc_d = {rx_crc_q[5:0], cmd_dat_i};
                end else if (cnt_q == CntRxCrcEnd) begin
                    end_d = cmd_dat_i;
                end

                if (cnt_q == CntRxDone) begin
                    if ((rx_crc_q != crc_q) && (rtype_q != RspNoCrc)) begin
                        status_d[1] = 1'b1;
                    end
                    if (!end_q) begin
                        status_d[2] = 1'b1;
                    end
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StDeliver;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDeliver: begin
                // Error flags persist until the next accepted command.
                if (ACK_IN) begin
                    req_d       = 1'b0;
                    status_d[0] = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset releases the pad immediately.
    always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
        if (!RST_PAD_I) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_q     <= '0;
            rtype_q   <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            end_q     <= 1'b0;
            rsp_q     <= '0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            status_q  <= '0;
            pad_out_q <= 1'b1;
            pad_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            rtype_q   <= rtype_d;
            crc_q     <= crc_d;
            rx_crc_q  <= rx_crc_d;
            end_q     <= end_d;
            rsp_q     <= rsp_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            status_q  <= status_d;
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
        end
    end

    assign ACK_OUT   = ack_q;
    assign REQ_OUT   = req_q;
    assign CMD_OUT   = rsp_q;
    assign STATUS    = {4'b0000, status_q};
    assign cmd_out_o = pad_out_q;
    assign cmd_oe_o  = pad_oe_q;

endmodule
